seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed N-digit seven-segment display driver, the parametrised successor to the single-digit 5-bit `Deco` glyph decoder. It latches a packed vector of per-digit 5-bit codes with a load strobe and commits it only at frame boundaries, so the display never tears. It scans one digit at a time at a programmable refresh rate, with a one-cycle anti-ghosting blank on every digit change. It sits between the board-level display pins and any logic that produces numeric or status codes.

## Interface
- `DIGITS`, default 4: number of digits scanned; minimum 2.
- `CODE_W`, fixed 5: code width per digit.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; minimum 2.
- `clk` in 1: system clock; all state on rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `load` in 1: capture `codes` into the pending register this cycle.
- `codes` in DIGITS*5: digit i occupies bits [5i+4:5i]; digit 0 is least significant, rightmost.
- `blank_mask` in DIGITS: bit i=1 forces digit i blank. Live input, not shadowed.
- `seg` out [0:6]: segments a..g, with seg[0]=a and seg[6]=g; active-low.
- `an` out DIGITS: digit enables, one-hot active-low; all-ones = off.
- `frame_start` out 1: one-cycle pulse when digit 0 becomes active.
- `pending` out 1: high while a loaded value awaits commit.

## Operation
- Glyphs, as on-segments:
  - 0–9: standard decimal glyphs.
  - 10–15: A, b, C, d, E, F.
  - 16: blank.
  - 17: '-' (g only).
  - 18: '_' (d only).
  - 19: degree (a, b, f, g).
  - 20–31: blank.
- Example glyph encodings, with `seg` listed a→g: code 0 → 0000001; code 8 → 0000000; code 17 → 1111110.
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and wraps. `tick` = (pcnt == REFRESH_DIV-1).
- Digit index `idx` advances on `tick`: DIGITS-1 → 0 wraps; otherwise idx+1.
- Load path:
  - `load`=1 copies `codes` into the pending register and sets `pending`.
  - Repeated loads before commit: last one wins.
- Commit:
  - Occurs on the `tick` where idx==DIGITS-1: pending → active register, `pending` cleared.
  - If `load` coincides with commit, the incoming `codes` are committed directly and `pending` ends 0.
- Digit i is blank if `blank_mask[i]`, its code is a blank code, or LZS applies (see Configuration).
- Reset mid-frame: all state is reinitialised immediately, including the pending value, which is discarded.

## Timing
- Reset values:
  - `pcnt`=0, `idx`=0.
  - Active and pending registers: all digits code 16.
  - `seg`=1111111, `an`=all ones, `frame_start`=0, `pending`=0.
- `seg` and `an` are registered and reflect `idx` and the active codes of the previous cycle: 1-cycle latency.
- Anti-ghost rule:
  - On the cycle after `tick`, `an`=all ones and `seg`=1111111 for exactly one cycle.
  - The new digit drives on the following cycle.
  - Each digit is therefore lit for REFRESH_DIV-1 cycles per slot.
- First digit after reset release: `an[0]`=0 on the 2nd rising edge after `rst_n` rises.
- `frame_start` pulses on the same cycle that `an[0]` first goes low in each frame.
- `blank_mask` changes take effect on `seg` 1 cycle later.
- Committed data is first visible at the digit-0 slot that follows the commit.

## Configuration
- `SEG7_LZS_EN` defined: leading-zero suppression.
  - Scanning from digit DIGITS-1 downward, every code-0 digit that precedes the first non-zero code is shown blank.
  - Digit 0 is never suppressed.
  - Blank codes (16, 20–31) count as zeros for this rule.
- `SEG7_LZS_EN` undefined: code 0 always shows '0'. No suppression logic is synthesised.

## Test plan
Use DIGITS=4 and REFRESH_DIV=4 for all scenarios.
- **Reset:**
  - Stimulus: hold `rst_n`=0 for 3 cycles, release.
  - Required: `seg`=1111111 and `an`=1111 during reset.
  - Required: `an`=1110 on the 2nd edge after release, with `seg`=1111111 (blank codes).
- **Full scan:**
  - Stimulus: load codes {3,2,1,0}, digit 3 first.
  - Required: after commit, `an` cycles 1110, 1101, 1011, 0111, with exactly one all-off cycle between digits.
  - Required: `seg` shows 0000001, 1001111, 0010010, 0000110.
  - Required: `frame_start` pulses once per 16 cycles.
- **Tear-free load:**
  - Stimulus: load {8,8,8,8} while idx=1.
  - Required: `pending`=1 until the idx=3 `tick`; the current frame is unchanged; the next frame shows 0000000 on all digits.
- **Coincident load/commit:**
  - Stimulus: load {9,9,9,9} earlier, then load {5,5,5,5} on the commit tick.
  - Required: the next frame shows 5 (0100100) on all digits; `pending`=0.
- **Blank mask and extended glyphs:**
  - Stimulus: codes {17,18,19,31} with `blank_mask`=0100.
  - Required: digit 3 = 1111110, digit 2 blank, digit 1 = 0011100, digit 0 = 1111111.
- **LZS** (with `SEG7_LZS_EN`):
  - Stimulus: codes {0,0,0,0}. Required: only digit 0 shows '0'.
  - Stimulus: codes {0,1,0,0}. Required: digit 3 blank; digits 2..0 show 1, 0, 0.
  - Without the macro: all zeros are displayed.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment driver.
// Latches per-digit 5-bit codes on `load`, commits them only at the end of a
// frame so the display never tears, and scans one digit per REFRESH_DIV
// cycles with a one-cycle all-off gap between digits.
// Optional feature: define SEG7_LZS_EN for leading-zero suppression.
module seg7_scan_driver #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned CODE_W      = 5,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [DIGITS*CODE_W-1:0] codes,
  input  logic [DIGITS-1:0]        blank_mask,
  output logic [0:6]               seg,
  output logic [DIGITS-1:0]        an,
  output logic                     frame_start,
  output logic                     pending
);

  localparam int unsigned        PCNT_W     = $clog2(REFRESH_DIV);
  localparam int unsigned        IDX_W      = $clog2(DIGITS);
  localparam logic [PCNT_W-1:0]  PCNT_LAST  = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [CODE_W-1:0]  CODE_BLANK = CODE_W'(16);

  // Glyph lookup: returns the lit segments, a in bit 6 down to g in bit 0.
  function automatic logic [6:0] glyph_on(input logic [CODE_W-1:0] c);
    logic [6:0] g;
    case (c)
      CODE_W'(0):  g = 7'b1111110;
      CODE_W'(1):  g = 7'b0110000;
      CODE_W'(2):  g = 7'b1101101;
      CODE_W'(3):  g = 7'b1111001;
      CODE_W'(4):  g = 7'b0110011;
      CODE_W'(5):  g = 7'b1011011;
      CODE_W'(6):  g = 7'b1011111;
      CODE_W'(7):  g = 7'b1110000;
      CODE_W'(8):  g = 7'b1111111;
      CODE_W'(9):  g = 7'b1111011;
      CODE_W'(10): g = 7'b1110111;
      CODE_W'(11): g = 7'b0011111;
      CODE_W'(12): g = 7'b1001110;
      CODE_W'(13): g = 7'b0111101;
      CODE_W'(14): g = 7'b1001111;
      CODE_W'(15): g = 7'b1000111;
      CODE_W'(17): g = 7'b0000001;
      CODE_W'(18): g = 7'b0001000;
      CODE_W'(19): g = 7'b1100011;
      default:     g = 7'b0000000;
    endcase
    return g;
  endfunction

  logic [PCNT_W-1:0]             pcnt_q, pcnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [DIGITS-1:0][CODE_W-1:0] pend_q, pend_d;
  logic [DIGITS-1:0][CODE_W-1:0] active_q, active_d;
  logic                          pending_q, pending_d;
  logic                          ghost_q, ghost_d;
  logic [0:6]                    seg_q, seg_d;
  logic [DIGITS-1:0]             an_q, an_d;
  logic                          frame_start_q, frame_start_d;
  logic                          tick;
  logic                          commit;
  logic [DIGITS-1:0]             sup;
  logic [CODE_W-1:0]             cur_code;

`ifdef SEG7_LZS_EN
  // Codes that read as "nothing shown" count as zeros for suppression.
  function automatic logic is_zero_like(input logic [CODE_W-1:0] c);
    return (c == '0) || (c == CODE_BLANK) || (c >= CODE_W'(20));
  endfunction

  // Leading-zero run from the top digit down; digit 0 always shown.
  always_comb begin
    logic run;
    run = 1'b1;
    sup = '0;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      run    = run & is_zero_like(active_q[i]);
      sup[i] = run;
    end
  end
`else
  // Suppression disabled: every digit shows its own glyph.
  always_comb begin
    sup = '0;
  end
`endif

  // Prescaler, digit index and frame-boundary load/commit bookkeeping.
  always_comb begin
    tick   = (pcnt_q == PCNT_LAST);
    commit = tick && (idx_q == IDX_LAST);
    pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    pend_d    = pend_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) begin
      pend_d    = codes;
      pending_d = 1'b1;
    end
    if (commit) begin
      active_d  = load ? codes : pend_q;
      pending_d = 1'b0;
    end
  end

  // Display outputs. ghost_q marks the cycle after a tick; blanking from it
  // (instead of from tick) gives the single off cycle between digits and
  // makes the first digit after reset appear on the second edge.
  always_comb begin
    ghost_d  = tick;
    cur_code = active_q[idx_q];
    an_d     = '1;
    seg_d    = '1;
    if (!ghost_q) begin
      an_d = ~(DIGITS'(1) << idx_q);
      if (!blank_mask[idx_q] && !sup[idx_q]) begin
        seg_d = ~glyph_on(cur_code);
      end
    end
    frame_start_d = an_q[0] & ~an_d[0];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q        <= '0;
      idx_q         <= '0;
      pend_q        <= {DIGITS{CODE_BLANK}};
      active_q      <= {DIGITS{CODE_BLANK}};
      pending_q     <= 1'b0;
      ghost_q       <= 1'b1;
      seg_q         <= '1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      ghost_q       <= ghost_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [19:0] codes;
  logic [3:0]  blank_mask;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic        frame_start;
  logic        pending;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S_0   = 7'b0000001;
  localparam logic [6:0] S_1   = 7'b1001111;
  localparam logic [6:0] S_2   = 7'b0010010;
  localparam logic [6:0] S_3   = 7'b0000110;
  localparam logic [6:0] S_5   = 7'b0100100;
  localparam logic [6:0] S_8   = 7'b0000000;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS      (4),
    .CODE_W      (5),
    .REFRESH_DIV (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .codes       (codes),
    .blank_mask  (blank_mask),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start),
    .pending     (pending)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got[6:0], exp[6:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one 16-cycle frame starting at its digit-0 slot, checking every
  // cycle against the hand-given per-digit glyphs. Up to two loads may be
  // issued at slot offsets ld1_k / ld2_k (-1 = none); commit is at offset 14.
  task automatic run_frame(input string name,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input int ld1_k, input logic [19:0] ld1_v,
                           input int ld2_k, input logic [19:0] ld2_v);
    logic [6:0] s [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_pend;
    int         d;
    int         p;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int k = 0; k < 16; k++) begin
      load = 1'b0;
      if (k == ld1_k) begin
        load  = 1'b1;
        codes = ld1_v;
      end
      if (k == ld2_k) begin
        load  = 1'b1;
        codes = ld2_v;
      end
      step();
      load     = 1'b0;
      d        = k / 4;
      p        = k % 4;
      exp_an   = (p == 3) ? 4'b1111 : ~(4'b0001 << d);
      exp_seg  = (p == 3) ? S_OFF : s[d];
      exp_pend = (ld1_k >= 0 && k >= ld1_k && k < 14) ||
                 (ld2_k >= 0 && k >= ld2_k && k < 14);
      check_eq($sformatf("%s k%0d an", name, k), 32'(an), 32'(exp_an));
      check_eq($sformatf("%s k%0d seg", name, k), 32'(seg), 32'(exp_seg));
      check_eq($sformatf("%s k%0d frame_start", name, k), 32'(frame_start), 32'(k == 0));
      check_eq($sformatf("%s k%0d pending", name, k), 32'(pending), 32'(exp_pend));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    codes      = '0;
    blank_mask = '0;
    repeat (3) @(negedge clk);
    check_eq("reset seg", 32'(seg), 32'(S_OFF));
    check_eq("reset an", 32'(an), 32'(4'b1111));
    check_eq("reset frame_start", 32'(frame_start), 32'(1'b0));
    check_eq("reset pending", 32'(pending), 32'(1'b0));

    rst_n = 1'b1;
    step();
    check_eq("edge1 an", 32'(an), 32'(4'b1111));
    check_eq("edge1 seg", 32'(seg), 32'(S_OFF));

    // Frame 0 shows reset blanks (an=1110 on the 2nd edge); load {3,2,1,0}.
    run_frame("F0", S_OFF, S_OFF, S_OFF, S_OFF,
              1, {5'd3, 5'd2, 5'd1, 5'd0}, -1, '0);
    // Full scan of the committed digits; tear-free load of 8s at idx=1.
    run_frame("F1", S_0, S_1, S_2, S_3,
              5, {5'd8, 5'd8, 5'd8, 5'd8}, -1, '0);
    // 8s now visible; 9s loaded, then 5s on the commit tick.
    run_frame("F2", S_8, S_8, S_8, S_8,
              6, {5'd9, 5'd9, 5'd9, 5'd9}, 14, {5'd5, 5'd5, 5'd5, 5'd5});
    run_frame("F3", S_5, S_5, S_5, S_5,
              2, {5'd17, 5'd18, 5'd19, 5'd31}, -1, '0);
    // Extended glyphs with digit 2 masked.
    blank_mask = 4'b0100;
    run_frame("F4", S_OFF, 7'b0011100, S_OFF, 7'b1111110,
              2, {5'd0, 5'd0, 5'd0, 5'd0}, -1, '0);
    blank_mask = 4'b0000;
`ifdef SEG7_LZS_EN
    run_frame("F5", S_0, S_OFF, S_OFF, S_OFF,
              2, {5'd0, 5'd1, 5'd0, 5'd0}, -1, '0);
    run_frame("F6", S_0, S_0, S_1, S_OFF, -1, '0, -1, '0);
`else
    run_frame("F5", S_0, S_0, S_0, S_0,
              2, {5'd0, 5'd1, 5'd0, 5'd0}, -1, '0);
    run_frame("F6", S_0, S_0, S_1, S_0, -1, '0, -1, '0);
`endif

    // Reset mid-frame with a value pending: it must be discarded.
    load  = 1'b1;
    codes = {5'd8, 5'd8, 5'd8, 5'd8};
    step();
    load = 1'b0;
    step();
    check_eq("midframe pending before reset", 32'(pending), 32'(1'b1));
    check_eq("midframe an before reset", 32'(an), 32'(4'b1110));
    rst_n = 1'b0;
    #1;
    check_eq("midframe reset an", 32'(an), 32'(4'b1111));
    check_eq("midframe reset seg", 32'(seg), 32'(S_OFF));
    check_eq("midframe reset pending", 32'(pending), 32'(1'b0));
    check_eq("midframe reset frame_start", 32'(frame_start), 32'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("rerelease edge1 an", 32'(an), 32'(4'b1111));
    run_frame("F7", S_OFF, S_OFF, S_OFF, S_OFF, -1, '0, -1, '0);
    run_frame("F8", S_OFF, S_OFF, S_OFF, S_OFF, -1, '0, -1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
